// File: rtl/adder_chk_pkg.sv
// rtl/adder_chk_pkg.sv - shared types and constants for the adder response checker
package adder_chk_pkg;

    localparam int ADDER_CHK_WIDTH = 8;
    localparam int VEC_W           = 3*ADDER_CHK_WIDTH+3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } chk_state_e;

    typedef struct packed {
        logic [ADDER_CHK_WIDTH-1:0] a;
        logic [ADDER_CHK_WIDTH-1:0] b;
        logic                       cin;
        logic [ADDER_CHK_WIDTH-1:0] sum;
        logic                       cout;
    } res_vec_t;

    localparam int RES_W = $bits(res_vec_t);

endpackage

// File: rtl/adder_chk_compare.sv
// rtl/adder_chk_compare.sv - registered stage-2 compare of one result vector against a+b+cin
module adder_chk_compare
    import adder_chk_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     in_valid,
    input  res_vec_t in_vec,
    output logic     out_valid,
    output logic     out_mismatch,
    output res_vec_t out_vec
);

    logic [ADDER_CHK_WIDTH:0] expected;
    logic                     valid_q, valid_d;
    logic                     mismatch_q, mismatch_d;
    res_vec_t                 vec_q, vec_d;

    always_comb begin
        expected   = {1'b0, in_vec.a} + {1'b0, in_vec.b}
                   + {{ADDER_CHK_WIDTH{1'b0}}, in_vec.cin};
        valid_d    = in_valid;
        mismatch_d = in_valid && (expected != {in_vec.cout, in_vec.sum});
        vec_d      = in_valid ? in_vec : vec_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            mismatch_q <= 1'b0;
            vec_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            mismatch_q <= mismatch_d;
            vec_q      <= vec_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_mismatch = mismatch_q;
    assign out_vec      = vec_q;

endmodule

// File: rtl/adder_response_checker.sv
// rtl/adder_response_checker.sv - stream scoreboard for simple_8bit_adder results
// Optional ADDER_CHK_STOP_ON_ERR_EN: end the run at the first detected mismatch.
module adder_response_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH       = ADDER_CHK_WIDTH,
    parameter int NUM_VECTORS = 131072,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_cin,
    input  logic [WIDTH-1:0]   in_sum,
    input  logic               in_cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   vec_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic               first_err_valid,
    output logic [3*WIDTH+2:0] first_err_vec
);

    chk_state_e       state_q, state_d;
    logic             s1_valid_q, s1_valid_d;
    res_vec_t         s1_vec_q, s1_vec_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fev_valid_q, fev_valid_d;
    res_vec_t         fev_q, fev_d;

    logic             cmp_valid;
    logic             cmp_mismatch;
    res_vec_t         cmp_vec;
    logic             stop_hit;
    logic             accept;

    adder_chk_compare u_compare (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (s1_valid_q),
        .in_vec       (s1_vec_q),
        .out_valid    (cmp_valid),
        .out_mismatch (cmp_mismatch),
        .out_vec      (cmp_vec)
    );

`ifdef ADDER_CHK_STOP_ON_ERR_EN
    assign stop_hit = cmp_valid && cmp_mismatch;
`else
    assign stop_hit = 1'b0;
`endif

    assign in_ready = (state_q == ST_RUN) && !stop_hit;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        s1_valid_d  = accept;
        s1_vec_d    = accept ? {in_a, in_b, in_cin, in_sum, in_cout} : s1_vec_q;
        acc_cnt_d   = accept ? acc_cnt_q + 1'b1 : acc_cnt_q;
        vec_cnt_d   = vec_cnt_q;
        err_cnt_d   = err_cnt_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fev_valid_d = fev_valid_q;
        fev_d       = fev_q;

        if (cmp_valid) begin
            vec_cnt_d = vec_cnt_q + 1'b1;
            if (cmp_mismatch) begin
                if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
                if (!fev_valid_q) begin
                    fev_valid_d = 1'b1;
                    fev_d       = cmp_vec;
                end
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    acc_cnt_d   = '0;
                    vec_cnt_d   = '0;
                    err_cnt_d   = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fev_valid_d = 1'b0;
                    fev_d       = '0;
                end
            end
            ST_RUN: begin
                if (stop_hit) begin
                    state_d = ST_DRAIN;
                end else if (accept && acc_cnt_q == CNT_W'(NUM_VECTORS - 1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Stage 2 retires its last vector on this edge, so judge on the next counts.
                if (!s1_valid_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0) && (vec_cnt_d == CNT_W'(NUM_VECTORS));
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s1_valid_q  <= 1'b0;
            s1_vec_q    <= '0;
            acc_cnt_q   <= '0;
            vec_cnt_q   <= '0;
            err_cnt_q   <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fev_valid_q <= 1'b0;
            fev_q       <= '0;
        end else begin
            state_q     <= state_d;
            s1_valid_q  <= s1_valid_d;
            s1_vec_q    <= s1_vec_d;
            acc_cnt_q   <= acc_cnt_d;
            vec_cnt_q   <= vec_cnt_d;
            err_cnt_q   <= err_cnt_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fev_valid_q <= fev_valid_d;
            fev_q       <= fev_d;
        end
    end

    assign busy            = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done            = done_q;
    assign pass            = pass_q;
    assign vec_cnt         = vec_cnt_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_valid = fev_valid_q;
    assign first_err_vec   = {{(3*WIDTH+3-RES_W){1'b0}}, fev_q};

endmodule

// File: tb/tb_adder_response_checker.sv
// tb/tb_adder_response_checker.sv - directed self-checking bench for adder_response_checker
module tb_adder_response_checker;

    localparam int NV     = 40;
    localparam int BUDGET = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        in_cin = 1'b0;
    logic [7:0]  in_sum = '0;
    logic        in_cout = 1'b0;
    logic        busy, done, pass;
    logic [31:0] vec_cnt, err_cnt;
    logic        first_err_valid;
    logic [26:0] first_err_vec;

    int n_checks = 0;
    int n_fail   = 0;

    adder_response_checker #(.WIDTH(8), .NUM_VECTORS(NV), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sum(in_sum), .in_cout(in_cout),
        .busy(busy), .done(done), .pass(pass),
        .vec_cnt(vec_cnt), .err_cnt(err_cnt),
        .first_err_valid(first_err_valid), .first_err_vec(first_err_vec)
    );

    always #5 clk = ~clk;

    // Vectors 0..2 are the carry boundaries; the rest are scattered operands.
    function automatic logic [16:0] vec_ops(input int idx);
        int a, b;
        case (idx)
            0: return {8'hFF, 8'h00, 1'b1};
            1: return {8'hFF, 8'hFF, 1'b1};
            2: return {8'h00, 8'h00, 1'b0};
            default: begin
                a = (idx * 29 + 7) % 256;
                b = (idx * 83 + 3) % 256;
                return {8'(a), 8'(b), 1'(idx % 2)};
            end
        endcase
    endfunction

    // Adder under check: 0 good, 1 cout stuck 0 on FF+00+1, 2 sum bit0 stuck 0, 3 bad vector #10
    function automatic logic [8:0] model_adder(input int idx, input int mode);
        logic [16:0] ops;
        logic [8:0]  r;
        ops = vec_ops(idx);
        r   = {1'b0, ops[16:9]} + {1'b0, ops[8:1]} + {8'h00, ops[0]};
        if (mode == 1 && ops == {8'hFF, 8'h00, 1'b1}) r[8] = 1'b0;
        if (mode == 2) r[0] = 1'b0;
        if (mode == 3 && idx == 9) r[0] = ~r[0];
        return r;
    endfunction

    task automatic expected_errors(input int mode, output int errs, output logic [26:0] fev);
        logic [8:0] good, got;
        errs = 0;
        fev  = '0;
        for (int i = 0; i < NV; i++) begin
            good = model_adder(i, 0);
            got  = model_adder(i, mode);
            if (got !== good) begin
                if (errs == 0) fev = {1'b0, vec_ops(i), got[7:0], got[8]};
                errs++;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if ({in_ready, busy, done, pass, first_err_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL %s_flags got ready/busy/done/pass/fev=%b want 00000", tag,
                     {in_ready, busy, done, pass, first_err_valid});
        end
        n_checks++;
        if (vec_cnt !== 32'd0 || err_cnt !== 32'd0 || first_err_vec !== 27'd0) begin
            n_fail++;
            $display("FAIL %s_regs got vec=%0d err=%0d fev=%h want 0 0 0", tag,
                     vec_cnt, err_cnt, first_err_vec);
        end
    endtask

    task automatic run_sweep(input int mode, input bit gaps, input bit mid_start,
                             output int accepts, output int lat);
        int cyc = 0;
        bit acc;
        logic [16:0] ops;
        logic [8:0]  res;
        accepts = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (accepts < NV && !done && cyc < BUDGET) begin
            ops = vec_ops(accepts);
            res = model_adder(accepts, mode);
            {in_a, in_b, in_cin} = ops;
            {in_cout, in_sum}    = res;
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            start    = (mid_start && cyc == 7);
            acc      = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            if (acc) accepts++;
            if (mid_start && cyc == 8) begin
                n_checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mid_start_ignored got busy=%b done=%b want 1 0", busy, done);
                end
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL run_timeout got done=%b want 1", done);
        end
    endtask

    task automatic check_result(input string tag, input int mode);
        int          errs;
        logic [26:0] fev;
        expected_errors(mode, errs, fev);
        n_checks++;
        if (vec_cnt !== 32'(NV)) begin
            n_fail++;
            $display("FAIL %s_vec_cnt got %0d want %0d", tag, vec_cnt, NV);
        end
        n_checks++;
        if (err_cnt !== 32'(errs)) begin
            n_fail++;
            $display("FAIL %s_err_cnt got %0d want %0d", tag, err_cnt, errs);
        end
        n_checks++;
        if (pass !== (errs == 0) || first_err_valid !== (errs != 0)) begin
            n_fail++;
            $display("FAIL %s_pass got pass=%b fev_valid=%b want %b %b", tag, pass,
                     first_err_valid, errs == 0, errs != 0);
        end
        n_checks++;
        if (first_err_vec !== fev) begin
            n_fail++;
            $display("FAIL %s_first_err_vec got %h want %h", tag, first_err_vec, fev);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        check_reset_values("reset");
    endtask

    task automatic test_clean_run();
        int acc, lat;
        run_sweep(0, 1'b0, 1'b0, acc, lat);
        n_checks++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL clean_done_latency got %0d want 2", lat);
        end
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_idle_flags got busy=%b ready=%b want 0 0", busy, in_ready);
        end
        check_result("clean", 0);
    endtask

    task automatic test_cout_fault();
        int acc, lat;
        run_sweep(1, 1'b0, 1'b0, acc, lat);
        check_result("cout_fault", 1);
        n_checks++;
        if (err_cnt !== 32'd1 || first_err_vec !== {1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL cout_fault_direct got err=%0d fev=%h want 1 %h", err_cnt,
                     first_err_vec, {1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0});
        end
    endtask

    task automatic test_sum_stuck();
        int acc, lat;
        run_sweep(2, 1'b0, 1'b0, acc, lat);
        check_result("sum_stuck", 2);
        n_checks++;
        if (first_err_vec !== {1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFE, 1'b1}) begin
            n_fail++;
            $display("FAIL sum_stuck_first got %h want %h", first_err_vec,
                     {1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFE, 1'b1});
        end
    endtask

    task automatic test_back_to_back_gaps();
        int acc, lat;
        run_sweep(0, 1'b1, 1'b1, acc, lat);
        check_result("gaps", 0);
    endtask

    task automatic test_reset_mid_run();
        int acc, lat, cyc;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        {in_a, in_b, in_cin, in_sum, in_cout} = {8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        cyc = 0;
        while (vec_cnt < 32'd10 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("post_reset");
        run_sweep(0, 1'b0, 1'b0, acc, lat);
        check_result("after_reset", 0);
    endtask

    task automatic test_stop_on_err();
        int acc, lat;
        run_sweep(3, 1'b0, 1'b0, acc, lat);
`ifdef ADDER_CHK_STOP_ON_ERR_EN
        n_checks++;
        if (!(vec_cnt == 32'd10 || vec_cnt == 32'd11) || err_cnt !== 32'd1 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_on_err got vec=%0d err=%0d pass=%b want 10|11 1 0",
                     vec_cnt, err_cnt, pass);
        end
        n_checks++;
        if (acc > 11) begin
            n_fail++;
            $display("FAIL stop_on_err_accepts got %0d want <=11", acc);
        end
`else
        check_result("late_err", 3);
`endif
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_cout_fault();
        test_sum_stuck();
        test_back_to_back_gaps();
        test_reset_mid_run();
        test_stop_on_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
